axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
AXI4 responder that terminates the memory-side AXI master of a switch processor. It backs the processor's table and counter accesses with an on-chip word array. Read and write channels run as independent state machines over a dual-ported register array. Lock, cache, prot and qos are not ported; the top level leaves those master outputs unconnected.

Parameters:
ID_WIDTH, 2, width of awid/bid/arid/rid
BASE_ADDR, 32'h0000_0000, byte address of word 0
DEPTH_WORDS, 1024, number of 32-bit words; power of two

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
axi_awid  in  ID_WIDTH  write burst ID
axi_awaddr  in  32  write start byte address
axi_awlen  in  8  beats minus 1
axi_awsize  in  3  ignored; beats are always 4 bytes
axi_awburst  in  2  00 FIXED; all other codes treated as INCR
axi_awvalid  in  1  AW valid
axi_awready  out  1  AW ready
axi_wdata  in  32  write data
axi_wstrb  in  4  byte enables
axi_wlast  in  1  last write beat
axi_wvalid  in  1  W valid
axi_wready  out  1  W ready
axi_bid  out  ID_WIDTH  echoed awid
axi_bresp  out  2  00 OKAY, 10 SLVERR
axi_bvalid  out  1  B valid
axi_bready  in  1  B ready
axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID_WIDTH/32/8/3/2/1  read address channel, same semantics as AW
axi_arready  out  1  AR ready
axi_rid  out  ID_WIDTH  echoed arid
axi_rdata  out  32  read data
axi_rresp  out  2  per-beat response
axi_rlast  out  1  last read beat
axi_rvalid  out  1  R valid
axi_rready  in  1  R ready

Behaviour:
- Reset (rst==0 at a clk edge): all outputs go to 0 and both FSMs go to idle. A reset mid-burst abandons the burst with no response. Array contents are preserved.
- Address map: in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. Word index = (addr-BASE_ADDR)>>2; addr[1:0] is ignored.
- Beat address: INCR adds 4 per beat, 32-bit wrap. FIXED holds the address constant.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1 from the first cycle after reset release. On awvalid&awready, latch id/addr/len/burst, clear the error flag, set awready=0 and wready=1.
  - W_DATA: on each wvalid&wready, write the enabled bytes if in range; otherwise set the error flag and drop the beat. Advance the address.
  - wlast is the sole terminator; the beat count is not checked against awlen. On wlast: wready=0, bvalid=1 in the next cycle, bresp = error ? 10 : 00.
  - W_RESP: bvalid holds until bready, then returns to W_IDLE with awready=1 in the following cycle.
  - Throughput: one write beat per cycle.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, latch fields and beat counter=arlen.
  - rvalid rises in the next cycle with rdata = word[first address], or 0 with rresp=10 if out of range.
  - R_DATA: rvalid, rdata, rresp, rid and rlast (counter==0) are held stable until rready.
  - On rvalid&rready with rlast=0: load the next beat in the same edge, so one beat per cycle back-to-back.
  - On rvalid&rready with rlast=1: rvalid=0 and arready=1 in the next cycle.
- Per-beat read errors: an INCR burst crossing the array end returns OKAY for in-range beats and SLVERR with data 0 for the rest.
- Simultaneous read and write to the same word in one cycle: the read returns the pre-write value; the write lands.
- Read and write bursts proceed concurrently, with no ordering between channels.
- Only one outstanding burst per channel; awready/arready stay low while that channel is busy.

Test Plan:
- Reset release: all outputs 0 during reset; awready=1 and arready=1 one cycle after rst goes high.
- Single write then read: AW addr 0x10, len 0, W 0xDEADBEEF strb 1111 -> bresp 00 one cycle after the W beat. AR 0x10 -> rdata 0xDEADBEEF, rlast=1, rresp 00, rid matches arid=2.
- INCR burst with backpressure: write len 3 to 0x0 with data 1,2,3,4. Read len 3 with rready toggling 1,0,1,0 -> rdata 1,2,3,4 held stable while stalled, rlast on the 4th beat only.
- Byte strobes and FIXED burst: preload 0x11223344, then write strb 0101 data 0xAABBCCDD -> read gives 0x11BB33DD. A FIXED write of len 1 with data 5 then 6 -> the word reads 6.
- Out-of-range crossing: INCR read len 1 starting at BASE+4*DEPTH-4 -> beat 0 OKAY, beat 1 data 0 with rresp 10. The matching write burst -> bresp 10, and the in-range word is still updated.
- Reset mid-burst plus concurrency: pull rst low after 2 of 4 read beats -> rvalid=0 the next cycle and a fresh AR is accepted after release. Overlapped read/write of the same word in the same cycle -> read returns the old value.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// -----------------------------------------------------------------------------
// axi_sram_slave_if
//
// AXI4 bus bundle between the switch processor's memory-side master and the
// on-chip SRAM responder. Lock, cache, prot and qos are deliberately absent:
// the responder has no use for them.
//
// Channels carried:
//   AW : awid, awaddr, awlen, awsize, awburst, awvalid / awready
//   W  : wdata, wstrb, wlast, wvalid / wready
//   B  : bid, bresp, bvalid / bready
//   AR : arid, araddr, arlen, arsize, arburst, arvalid / arready
//   R  : rid, rdata, rresp, rlast, rvalid / rready
//
// Modports:
//   master : drives the request channels and the response readies
//   slave  : drives the request readies and the response channels
// -----------------------------------------------------------------------------
interface axi_sram_slave_if #(
    parameter int unsigned ID_WIDTH = 2
);
    // write address channel
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    // write data channel
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    // write response channel
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    // read address channel
    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    // read data channel
    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// AXI4 responder backing the switch processor's table and counter accesses
// with an on-chip array of 32-bit words. The write and read channels are two
// independent state machines sharing a dual-ported register array, so read
// and write bursts run concurrently with no ordering between them.
//
// Handshake rule used on every channel: a transfer happens on the rising
// clk edge where both valid and ready are high. The sender holds its payload
// stable while valid is high and ready is low; this block never makes its own
// valid depend combinationally on the peer's ready.
//
// Ports:
//   clk         : clock
//   rst         : synchronous reset, active-low; array contents survive it
//   axi         : AXI4 slave modport (AW, W, B, AR, R channels)
//   dbg_w_state : current write FSM state (W_IDLE=0, W_DATA=1, W_RESP=2)
//   dbg_r_state : current read FSM state  (R_IDLE=0, R_DATA=1)
//
// Addressing: a byte address is in range when
//   BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS,
// word index = (addr - BASE_ADDR) >> 2, addr[1:0] ignored. INCR bursts step
// by 4 with 32-bit wrap; FIXED bursts hold the start address. awsize/arsize
// are ignored (beats are always 4 bytes) and awlen is not used: wlast alone
// ends a write burst.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int unsigned ID_WIDTH    = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_sram_slave_if.slave        axi,
    output logic [1:0]             dbg_w_state,
    output logic [1:0]             dbg_r_state
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Byte span of the array, one bit wider than the bus so the limit itself
    // can be represented when the array reaches the top of the address space.
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // -------------------------------------------------------------------------
    // Address helpers
    // -------------------------------------------------------------------------
    function automatic logic addr_in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a - BASE_ADDR};
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    // -------------------------------------------------------------------------
    // Storage. No reset: contents are preserved across rst.
    // -------------------------------------------------------------------------
    logic [31:0] mem [DEPTH_WORDS];

    // -------------------------------------------------------------------------
    // Write channel FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    w_state_t            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] w_id_q,    w_id_d;
    logic [31:0]         w_addr_q,  w_addr_d;
    logic                w_fixed_q, w_fixed_d;
    logic                w_err_q,   w_err_d;
    logic                awready_q, awready_d;
    logic                wready_q,  wready_d;
    logic                bvalid_q,  bvalid_d;
    logic [1:0]          bresp_q,   bresp_d;

    logic                w_beat;
    logic                w_hit;
    logic                mem_we;
    logic [IDX_W-1:0]    w_index;

    assign w_beat  = (w_state_q == W_DATA) && axi.wvalid && wready_q;
    assign w_hit   = addr_in_range(w_addr_q);
    assign w_index = addr_index(w_addr_q);
    // A beat arriving on a reset edge is abandoned along with its burst.
    assign mem_we  = rst && w_beat && w_hit;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        unique case (w_state_q)
            W_IDLE: begin
                // awready comes up on the first cycle after reset release.
                awready_d = 1'b1;
                if (axi.awvalid && awready_q) begin
                    w_id_d    = axi.awid;
                    w_addr_d  = axi.awaddr;
                    w_fixed_d = (axi.awburst == 2'b00);
                    w_err_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end

            W_DATA: begin
                if (w_beat) begin
                    if (!w_hit) begin
                        w_err_d = 1'b1;
                    end
                    if (!w_fixed_q) begin
                        w_addr_d = w_addr_q + 32'd4;
                    end
                    // wlast ends the burst regardless of how many beats
                    // were announced; the current beat's error counts too.
                    if (axi.wlast) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || !w_hit) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end

            W_RESP: begin
                if (bvalid_q && axi.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end

            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-enabled array write. A read loading from the same word on the
    // same edge samples the old contents because this update is non-blocking.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) begin
                    mem[w_index][8*b +: 8] <= axi.wdata[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read channel FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1
    } r_state_t;

    r_state_t            r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] r_id_q,    r_id_d;
    logic [31:0]         r_addr_q,  r_addr_d;
    logic                r_fixed_q, r_fixed_d;
    logic [7:0]          r_cnt_q,   r_cnt_d;
    logic                arready_q, arready_d;
    logic                rvalid_q,  rvalid_d;
    logic [31:0]         rdata_q,   rdata_d;
    logic [1:0]          rresp_q,   rresp_d;
    logic                rlast_q,   rlast_d;

    // Beat loader: one address/count pair feeds both the first beat (from
    // AR) and every following beat, so the R register is refilled on the
    // same edge that retires the current beat.
    logic                load;
    logic [31:0]         load_addr;
    logic [7:0]          load_cnt;
    logic                load_hit;
    logic [31:0]         load_word;

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_fixed_d = r_fixed_q;
        r_cnt_d   = r_cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        load      = 1'b0;
        load_addr = r_addr_q;
        load_cnt  = r_cnt_q;

        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi.arvalid && arready_q) begin
                    r_id_d    = axi.arid;
                    r_fixed_d = (axi.arburst == 2'b00);
                    load      = 1'b1;
                    load_addr = axi.araddr;
                    load_cnt  = axi.arlen;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end

            R_DATA: begin
                if (rvalid_q && axi.rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        load      = 1'b1;
                        load_addr = r_fixed_q ? r_addr_q : (r_addr_q + 32'd4);
                        load_cnt  = r_cnt_q - 8'd1;
                    end
                end
            end

            default: begin
                r_state_d = R_IDLE;
            end
        endcase

        load_hit  = addr_in_range(load_addr);
        load_word = mem[addr_index(load_addr)];

        if (load) begin
            r_addr_d = load_addr;
            r_cnt_d  = load_cnt;
            rvalid_d = 1'b1;
            rlast_d  = (load_cnt == 8'd0);
            rdata_d  = load_hit ? load_word : 32'd0;
            rresp_d  = load_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_fixed_q <= 1'b0;
            r_cnt_q   <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_fixed_q <= r_fixed_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bid     = w_id_q;
    assign axi.bresp   = bresp_q;
    assign axi.bvalid  = bvalid_q;

    assign axi.arready = arready_q;
    assign axi.rid     = r_id_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
    assign axi.rvalid  = rvalid_q;

    assign dbg_w_state = w_state_q;
    assign dbg_r_state = r_state_q;

    // Fields accepted on the bus but carrying no meaning for this responder.
    logic unused_fields;
    assign unused_fields = ^{axi.awlen, axi.awsize, axi.arsize};

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Drives AXI bursts into axi_sram_slave and compares every response against a
// word-array reference model computed from the address-map and burst rules.
// Inputs are driven and outputs sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

    localparam int          ID_WIDTH    = 2;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam int          DEPTH_WORDS = 1024;
    localparam int          TIMEOUT     = 400;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    axi_sram_slave_if #(.ID_WIDTH(ID_WIDTH)) axi ();
    logic [1:0] dbg_w_state;
    logic [1:0] dbg_r_state;

    axi_sram_slave #(
        .ID_WIDTH   (ID_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_WORDS(DEPTH_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .axi        (axi),
        .dbg_w_state(dbg_w_state),
        .dbg_r_state(dbg_r_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [DEPTH_WORDS];

    function automatic bit ref_hit(input logic [31:0] a);
        longint ua;
        longint lo;
        ua = longint'(a);
        lo = longint'(BASE_ADDR);
        return (ua >= lo) && (ua < lo + 4 * DEPTH_WORDS);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input bit fixed, input int i);
        return fixed ? start : start + 32'(4 * i);
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (ref_hit(a)) begin
            idx = int'((a - BASE_ADDR) >> 2);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    function automatic void ref_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        if (ref_hit(a)) begin
            d = ref_mem[int'((a - BASE_ADDR) >> 2)];
            r = 2'b00;
        end else begin
            d = 32'd0;
            r = 2'b10;
        end
    endfunction

    // ---------------- driver state ----------------
    logic [31:0]         wr_data_q [$];
    logic [3:0]          wr_strb_q [$];
    logic [31:0]         obs_data  [$];
    logic [1:0]          obs_resp  [$];
    logic                obs_last  [$];
    logic [ID_WIDTH-1:0] obs_id    [$];
    int                  obs_beat  [$];

    // Queue a write burst's beats into the model and return the expected bresp.
    function automatic logic [1:0] ref_write_burst(input logic [31:0] a, input bit fixed);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < wr_data_q.size(); i++) begin
            if (!ref_hit(beat_addr(a, fixed, i))) r = 2'b10;
            ref_write(beat_addr(a, fixed, i), wr_data_q[i], wr_strb_q[i]);
        end
        return r;
    endfunction

    task automatic write_burst(input logic [31:0] addr, input bit fixed, input logic [ID_WIDTH-1:0] id,
                               output logic [1:0] resp, output logic [ID_WIDTH-1:0] bid,
                               output int b_wait, output int w_stall);
        int t;
        axi.awid    = id;
        axi.awaddr  = addr;
        axi.awlen   = 8'(wr_data_q.size() - 1);
        axi.awsize  = 3'd2;
        axi.awburst = fixed ? 2'b00 : 2'b01;
        axi.awvalid = 1'b1;
        t = 0;
        while (!axi.awready && t < TIMEOUT) begin step(); t++; end
        if (t >= TIMEOUT) begin
            n_checks++; n_errors++;
            $display("FAIL aw_timeout: awready stayed 0 for %0d cycles, required 1", t);
        end
        step();
        axi.awvalid = 1'b0;
        w_stall = 0;
        for (int i = 0; i < wr_data_q.size(); i++) begin
            axi.wdata  = wr_data_q[i];
            axi.wstrb  = wr_strb_q[i];
            axi.wlast  = (i == wr_data_q.size() - 1);
            axi.wvalid = 1'b1;
            t = 0;
            while (!axi.wready && t < TIMEOUT) begin step(); t++; w_stall++; end
            step();
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        axi.bready = 1'b1;
        b_wait = 0;
        while (!axi.bvalid && b_wait < TIMEOUT) begin step(); b_wait++; end
        resp = axi.bresp;
        bid  = axi.bid;
        step();
        axi.bready = 1'b0;
    endtask

    // mode 0: rready always 1; mode 1: rready 1,0,1,0...; mode 2: random.
    task automatic read_burst(input logic [31:0] addr, input bit fixed, input int len,
                              input logic [ID_WIDTH-1:0] id, input int mode,
                              output int beats_done, output int cycles);
        int t;
        obs_data.delete(); obs_resp.delete(); obs_last.delete(); obs_id.delete(); obs_beat.delete();
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = 8'(len);
        axi.arsize  = 3'd2;
        axi.arburst = fixed ? 2'b00 : 2'b01;
        axi.arvalid = 1'b1;
        t = 0;
        while (!axi.arready && t < TIMEOUT) begin step(); t++; end
        if (t >= TIMEOUT) begin
            n_checks++; n_errors++;
            $display("FAIL ar_timeout: arready stayed 0 for %0d cycles, required 1", t);
        end
        step();
        axi.arvalid = 1'b0;
        beats_done = 0;
        cycles = 0;
        t = 0;
        while (beats_done <= len && t < TIMEOUT) begin
            case (mode)
                0:       axi.rready = 1'b1;
                1:       axi.rready = (t % 2 == 0);
                default: axi.rready = 1'($urandom_range(0, 1));
            endcase
            if (axi.rvalid) begin
                obs_data.push_back(axi.rdata);
                obs_resp.push_back(axi.rresp);
                obs_last.push_back(axi.rlast);
                obs_id.push_back(axi.rid);
                obs_beat.push_back(beats_done);
                if (axi.rready) beats_done++;
            end
            step();
            t++;
            cycles++;
        end
        axi.rready = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 32'(4 * DEPTH_WORDS - 4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            1:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
            default: return 32'($urandom_range(0, 4 * DEPTH_WORDS - 1));
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({axi.awready, axi.wready, axi.bvalid, axi.bresp, axi.bid, axi.arready,
             axi.rvalid, axi.rdata, axi.rresp, axi.rlast, axi.rid} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: awready=%b wready=%b bvalid=%b arready=%b rvalid=%b rdata=%h, required all 0",
                     axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rdata);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (axi.awready !== 1'b1 || axi.arready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: awready=%b arready=%b, required 1 1", axi.awready, axi.arready);
        end
    endtask

    task automatic test_fill();
        logic [1:0] resp; logic [ID_WIDTH-1:0] bid; int bw, ws, nb, cyc;
        logic [31:0] ed; logic [1:0] er; logic [31:0] a;
        for (int blk = 0; blk < 4; blk++) begin
            wr_data_q.delete(); wr_strb_q.delete();
            for (int i = 0; i < 256; i++) begin
                wr_data_q.push_back($urandom);
                wr_strb_q.push_back(4'hF);
            end
            a = BASE_ADDR + 32'(blk * 1024);
            write_burst(a, 1'b0, 2'(blk), resp, bid, bw, ws);
            void'(ref_write_burst(a, 1'b0));
            n_checks++;
            if (resp !== 2'b00 || bid !== 2'(blk) || ws !== 0) begin
                n_errors++;
                $display("FAIL fill_write: bresp=%b bid=%0d stalls=%0d, required 00 %0d 0", resp, bid, ws, blk);
            end
        end
        for (int n = 0; n < 4; n++) begin
            a = 32'($urandom_range(0, DEPTH_WORDS - 16) * 4);
            read_burst(a, 1'b0, 15, 2'(n), 0, nb, cyc);
            for (int k = 0; k < obs_data.size(); k++) begin
                ref_read(beat_addr(a, 1'b0, obs_beat[k]), ed, er);
                n_checks++;
                if (obs_data[k] !== ed || obs_resp[k] !== er || obs_last[k] !== (obs_beat[k] == 15) || obs_id[k] !== 2'(n)) begin
                    n_errors++;
                    $display("FAIL fill_read beat %0d: data=%h resp=%b last=%b id=%0d, required %h %b %b %0d",
                             obs_beat[k], obs_data[k], obs_resp[k], obs_last[k], obs_id[k], ed, er, obs_beat[k] == 15, n);
                end
            end
            n_checks++;
            if (nb !== 16 || cyc !== 16) begin
                n_errors++;
                $display("FAIL fill_read_throughput: beats=%0d cycles=%0d, required 16 16", nb, cyc);
            end
        end
    endtask

    task automatic test_single();
        logic [1:0] resp; logic [ID_WIDTH-1:0] bid; int bw, ws, nb, cyc;
        wr_data_q = '{32'hDEAD_BEEF};
        wr_strb_q = '{4'hF};
        write_burst(32'h10, 1'b0, 2'd1, resp, bid, bw, ws);
        void'(ref_write_burst(32'h10, 1'b0));
        n_checks++;
        if (resp !== 2'b00 || bid !== 2'd1 || bw !== 0) begin
            n_errors++;
            $display("FAIL single_write: bresp=%b bid=%0d bvalid_delay=%0d, required 00 1 0", resp, bid, bw);
        end
        read_burst(32'h10, 1'b0, 0, 2'd2, 0, nb, cyc);
        n_checks++;
        if (nb !== 1 || obs_data[0] !== 32'hDEAD_BEEF || obs_resp[0] !== 2'b00 || obs_last[0] !== 1'b1 || obs_id[0] !== 2'd2) begin
            n_errors++;
            $display("FAIL single_read: beats=%0d data=%h resp=%b last=%b id=%0d, required 1 deadbeef 00 1 2",
                     nb, obs_data[0], obs_resp[0], obs_last[0], obs_id[0]);
        end
    endtask

    task automatic test_incr_backpressure();
        logic [1:0] resp; logic [ID_WIDTH-1:0] bid; int bw, ws, nb, cyc;
        logic [31:0] ed; logic [1:0] er;
        wr_data_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        wr_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        write_burst(32'h0, 1'b0, 2'd3, resp, bid, bw, ws);
        void'(ref_write_burst(32'h0, 1'b0));
        n_checks++;
        if (resp !== 2'b00 || ws !== 0) begin
            n_errors++;
            $display("FAIL incr_write: bresp=%b stalls=%0d, required 00 0", resp, ws);
        end
        read_burst(32'h0, 1'b0, 3, 2'd1, 1, nb, cyc);
        for (int k = 0; k < obs_data.size(); k++) begin
            ref_read(beat_addr(32'h0, 1'b0, obs_beat[k]), ed, er);
            n_checks++;
            if (obs_data[k] !== ed || obs_data[k] !== 32'(obs_beat[k] + 1) || obs_resp[k] !== er ||
                obs_last[k] !== (obs_beat[k] == 3) || obs_id[k] !== 2'd1) begin
                n_errors++;
                $display("FAIL incr_read beat %0d: data=%h resp=%b last=%b, required %h %b %b",
                         obs_beat[k], obs_data[k], obs_resp[k], obs_last[k], ed, er, obs_beat[k] == 3);
            end
        end
        n_checks++;
        if (nb !== 4) begin
            n_errors++;
            $display("FAIL incr_read_count: beats=%0d, required 4", nb);
        end
    endtask

    task automatic test_strobe_fixed();
        logic [1:0] resp; logic [ID_WIDTH-1:0] bid; int bw, ws, nb, cyc;
        logic [31:0] ed; logic [1:0] er;
        wr_data_q = '{32'h1122_3344}; wr_strb_q = '{4'hF};
        write_burst(32'h20, 1'b0, 2'd0, resp, bid, bw, ws);
        void'(ref_write_burst(32'h20, 1'b0));
        wr_data_q = '{32'hAABB_CCDD}; wr_strb_q = '{4'b0101};
        write_burst(32'h20, 1'b0, 2'd0, resp, bid, bw, ws);
        void'(ref_write_burst(32'h20, 1'b0));
        read_burst(32'h20, 1'b0, 0, 2'd0, 0, nb, cyc);
        n_checks++;
        if (nb !== 1 || obs_data[0] !== 32'h11BB_33DD || obs_resp[0] !== 2'b00) begin
            n_errors++;
            $display("FAIL strobe_merge: data=%h resp=%b, required 11bb33dd 00", obs_data[0], obs_resp[0]);
        end
        ref_read(32'h28, ed, er);
        wr_data_q = '{32'd5, 32'd6}; wr_strb_q = '{4'hF, 4'hF};
        write_burst(32'h24, 1'b1, 2'd2, resp, bid, bw, ws);
        void'(ref_write_burst(32'h24, 1'b1));
        read_burst(32'h24, 1'b0, 1, 2'd3, 2, nb, cyc);
        n_checks++;
        if (nb !== 2 || obs_data[obs_data.size()-2] !== 32'd6 || obs_data[obs_data.size()-1] !== ed) begin
            n_errors++;
            $display("FAIL fixed_write: word24=%h word28=%h, required 00000006 %h",
                     obs_data[obs_data.size()-2], obs_data[obs_data.size()-1], ed);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [ID_WIDTH-1:0] bid; int bw, ws, nb, cyc;
        logic [31:0] ed; logic [1:0] er; logic [31:0] a; logic [31:0] v;
        a = BASE_ADDR + 32'(4 * DEPTH_WORDS - 4);
        read_burst(a, 1'b0, 1, 2'd1, 0, nb, cyc);
        ref_read(a, ed, er);
        n_checks++;
        if (nb !== 2 || obs_data[0] !== ed || obs_resp[0] !== 2'b00 || obs_data[1] !== 32'd0 ||
            obs_resp[1] !== 2'b10 || obs_last[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_read: b0=%h/%b b1=%h/%b last=%b, required %h/00 00000000/10 1",
                     obs_data[0], obs_resp[0], obs_data[1], obs_resp[1], obs_last[1], ed);
        end
        v = $urandom;
        wr_data_q = '{v, $urandom}; wr_strb_q = '{4'hF, 4'hF};
        write_burst(a, 1'b0, 2'd2, resp, bid, bw, ws);
        void'(ref_write_burst(a, 1'b0));
        n_checks++;
        if (resp !== 2'b10 || bid !== 2'd2) begin
            n_errors++;
            $display("FAIL oor_write_resp: bresp=%b bid=%0d, required 10 2", resp, bid);
        end
        read_burst(a, 1'b0, 0, 2'd0, 0, nb, cyc);
        n_checks++;
        if (obs_data[0] !== v || obs_resp[0] !== 2'b00) begin
            n_errors++;
            $display("FAIL oor_write_inrange: data=%h resp=%b, required %h 00", obs_data[0], obs_resp[0], v);
        end
        // Start near the top of the 32-bit space: beats wrap back into the array.
        a = 32'hFFFF_FFF8;
        read_burst(a, 1'b0, 3, 2'd3, 2, nb, cyc);
        for (int k = 0; k < obs_data.size(); k++) begin
            ref_read(beat_addr(a, 1'b0, obs_beat[k]), ed, er);
            n_checks++;
            if (obs_data[k] !== ed || obs_resp[k] !== er || obs_last[k] !== (obs_beat[k] == 3)) begin
                n_errors++;
                $display("FAIL wrap_read beat %0d: data=%h resp=%b last=%b, required %h %b %b",
                         obs_beat[k], obs_data[k], obs_resp[k], obs_last[k], ed, er, obs_beat[k] == 3);
            end
        end
    endtask

    task automatic test_same_word();
        logic [31:0] a, old_v, new_v; logic [1:0] er; int t, nb, cyc;
        a = 32'h40;
        ref_read(a, old_v, er);
        new_v = ~old_v;
        axi.awid = 2'd1; axi.awaddr = a; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'b01; axi.awvalid = 1'b1;
        t = 0;
        while (!axi.awready && t < TIMEOUT) begin step(); t++; end
        step();
        axi.awvalid = 1'b0;
        axi.wdata = new_v; axi.wstrb = 4'hF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
        axi.arid = 2'd2; axi.araddr = a; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        n_checks++;
        if (axi.wready !== 1'b1 || axi.arready !== 1'b1) begin
            n_errors++;
            $display("FAIL same_word_align: wready=%b arready=%b, required 1 1", axi.wready, axi.arready);
        end
        step();
        axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.arvalid = 1'b0;
        n_checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== old_v || axi.rresp !== 2'b00 || axi.rlast !== 1'b1 || axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
            n_errors++;
            $display("FAIL same_word_read: rvalid=%b rdata=%h bvalid=%b bresp=%b, required 1 %h 1 00",
                     axi.rvalid, axi.rdata, axi.bvalid, axi.bresp, old_v);
        end
        axi.rready = 1'b1; axi.bready = 1'b1;
        step();
        axi.rready = 1'b0; axi.bready = 1'b0;
        ref_write(a, new_v, 4'hF);
        read_burst(a, 1'b0, 0, 2'd0, 0, nb, cyc);
        n_checks++;
        if (obs_data[0] !== new_v) begin
            n_errors++;
            $display("FAIL same_word_landed: data=%h, required %h", obs_data[0], new_v);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] resp; logic [ID_WIDTH-1:0] bid; int bw, ws, nb, cyc;
        logic [31:0] ed; logic [1:0] er;
        logic [31:0] exp_q [$];
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            ref_read(32'h200 + 32'(4 * i), ed, er);
            exp_q.push_back(ed);
        end
        wr_data_q.delete(); wr_strb_q.delete();
        for (int i = 0; i < 8; i++) begin
            wr_data_q.push_back($urandom);
            wr_strb_q.push_back(4'($urandom_range(0, 15)));
        end
        fork
            write_burst(32'h100, 1'b0, 2'd1, resp, bid, bw, ws);
            read_burst(32'h200, 1'b0, 7, 2'd2, 2, nb, cyc);
        join
        void'(ref_write_burst(32'h100, 1'b0));
        n_checks++;
        if (resp !== 2'b00 || nb !== 8) begin
            n_errors++;
            $display("FAIL concurrent_done: bresp=%b beats=%0d, required 00 8", resp, nb);
        end
        for (int k = 0; k < obs_data.size(); k++) begin
            n_checks++;
            if (obs_data[k] !== exp_q[obs_beat[k]] || obs_resp[k] !== 2'b00 || obs_last[k] !== (obs_beat[k] == 7)) begin
                n_errors++;
                $display("FAIL concurrent_read beat %0d: data=%h last=%b, required %h %b",
                         obs_beat[k], obs_data[k], obs_last[k], exp_q[obs_beat[k]], obs_beat[k] == 7);
            end
        end
        read_burst(32'h100, 1'b0, 7, 2'd3, 0, nb, cyc);
        for (int k = 0; k < obs_data.size(); k++) begin
            ref_read(32'h100 + 32'(4 * obs_beat[k]), ed, er);
            n_checks++;
            if (obs_data[k] !== ed) begin
                n_errors++;
                $display("FAIL concurrent_write beat %0d: data=%h, required %h", obs_beat[k], obs_data[k], ed);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, eresp; logic [ID_WIDTH-1:0] bid, id; int bw, ws, nb, cyc, len;
        logic [31:0] ed; logic [1:0] er; logic [31:0] a; bit fx;
        for (int it = 0; it < 25; it++) begin
            a = pick_addr(); fx = ($urandom_range(0, 3) == 0); len = $urandom_range(0, 7);
            id = 2'($urandom_range(0, 3));
            wr_data_q.delete(); wr_strb_q.delete();
            for (int i = 0; i <= len; i++) begin
                wr_data_q.push_back($urandom);
                wr_strb_q.push_back(4'($urandom_range(0, 15)));
            end
            write_burst(a, fx, id, resp, bid, bw, ws);
            eresp = ref_write_burst(a, fx);
            n_checks++;
            if (resp !== eresp || bid !== id || bw !== 0 || ws !== 0) begin
                n_errors++;
                $display("FAIL rand_write %0d: bresp=%b bid=%0d bdelay=%0d stalls=%0d, required %b %0d 0 0",
                         it, resp, bid, bw, ws, eresp, id);
            end
            a = pick_addr(); fx = ($urandom_range(0, 3) == 0); len = $urandom_range(0, 7);
            id = 2'($urandom_range(0, 3));
            read_burst(a, fx, len, id, 2, nb, cyc);
            n_checks++;
            if (nb !== len + 1) begin
                n_errors++;
                $display("FAIL rand_read_count %0d: beats=%0d, required %0d", it, nb, len + 1);
            end
            for (int k = 0; k < obs_data.size(); k++) begin
                ref_read(beat_addr(a, fx, obs_beat[k]), ed, er);
                n_checks++;
                if (obs_data[k] !== ed || obs_resp[k] !== er || obs_last[k] !== (obs_beat[k] == len) || obs_id[k] !== id) begin
                    n_errors++;
                    $display("FAIL rand_read %0d beat %0d: data=%h resp=%b last=%b id=%0d, required %h %b %b %0d",
                             it, obs_beat[k], obs_data[k], obs_resp[k], obs_last[k], obs_id[k], ed, er, obs_beat[k] == len, id);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int t, acc, nb, cyc; logic [31:0] ed; logic [1:0] er;
        axi.arid = 2'd1; axi.araddr = 32'h80; axi.arlen = 8'd3; axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        t = 0;
        while (!axi.arready && t < TIMEOUT) begin step(); t++; end
        step();
        axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        acc = 0; t = 0;
        while (acc < 2 && t < TIMEOUT) begin
            if (axi.rvalid) acc++;
            step();
            t++;
        end
        rst = 1'b0;
        axi.rready = 1'b0;
        step();
        n_checks++;
        if (axi.rvalid !== 1'b0 || acc !== 2) begin
            n_errors++;
            $display("FAIL reset_mid_burst: rvalid=%b accepted=%0d, required 0 2", axi.rvalid, acc);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (axi.arready !== 1'b1 || axi.rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_release: arready=%b rvalid=%b, required 1 0", axi.arready, axi.rvalid);
        end
        read_burst(32'h80, 1'b0, 3, 2'd2, 0, nb, cyc);
        n_checks++;
        if (nb !== 4) begin
            n_errors++;
            $display("FAIL reset_mid_fresh_count: beats=%0d, required 4", nb);
        end
        for (int k = 0; k < obs_data.size(); k++) begin
            ref_read(32'h80 + 32'(4 * obs_beat[k]), ed, er);
            n_checks++;
            if (obs_data[k] !== ed || obs_resp[k] !== er || obs_last[k] !== (obs_beat[k] == 3)) begin
                n_errors++;
                $display("FAIL reset_mid_fresh beat %0d: data=%h resp=%b, required %h %b",
                         obs_beat[k], obs_data[k], obs_resp[k], ed, er);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        test_reset();
        test_fill();
        test_single();
        test_incr_backpressure();
        test_strobe_fixed();
        test_out_of_range();
        test_same_word();
        test_concurrent();
        test_random();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
